mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, owns the HI/LO registers, and services MTHI/MTLO and MFHI/MFLO. It drives `busy_or_start`, the signal the forwarding/stall controller combines with its "MD-class instruction in D" decode to stall D while the unit is occupied.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: synchronous, active-high.
- `md_op` input, 3 bits: E-stage op.
  - 0 = none, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO, 7 = reserved (treated as none).
- `rs_val` input, 32 bits: forwarded rs operand (dividend / multiplicand / MT source).
- `rt_val` input, 32 bits: forwarded rt operand (divisor / multiplier).
- `start` output, 1 bit: combinational; `md_op` is in 1..4 and `busy`=0.
- `busy` output, 1 bit: registered; an operation is in flight.
- `busy_or_start` output, 1 bit: `start | busy`, for the stall controller.
- `hi` output, 32 bits: HI register (MFHI source).
- `lo` output, 32 bits: LO register (MFLO source).

## Operation
- Registered state:
  - `hi`, `lo`
  - `busy`
  - down-counter `cnt`, wide enough for `max(MULT_CYCLES, DIV_CYCLES)`
  - latched op
  - latched 32-bit operands
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, `cnt` counts down).
- IDLE → RUN when `start`=1:
  - Latch op, `rs_val`, `rt_val`.
  - `cnt` ← `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy` ← 1.
- RUN:
  - Each cycle `cnt` ← `cnt`-1.
  - On the edge where `cnt`==1: write result to `hi`/`lo`, set `busy` ← 0, return to IDLE.
- Results, computed from the latched operands only:
  - MULT: {hi,lo} = signed 32×32 → 64-bit product.
  - MULTU: {hi,lo} = unsigned 32×32 → 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder, sign follows dividend.
    - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU: lo = unsigned quotient, hi = unsigned remainder.
  - Divisor 0 (DIV/DIVU): hi/lo unchanged; busy timing identical to a normal divide.
- MTHI/MTLO in IDLE: `hi` (resp. `lo`) ← `rs_val` at the next edge; `busy` stays 0.
- Ops 1..6 arriving while `busy`=1 are ignored. The stall controller prevents issue; the unit does not rely on it.
- `md_op` 0 or 7: no state change.
- `hi`/`lo` are read directly by MFHI/MFLO. While `busy`=1 they hold the previous values; reads are stalled upstream.

## Timing
- Reset (synchronous, takes priority over everything):
  - `hi`=0, `lo`=0, `busy`=0, `cnt`=0.
  - Latched op = none.
  - `start`/`busy_or_start` then follow `md_op` combinationally.
- Reset while in RUN aborts the operation. No result is written; `hi`/`lo`=0.
- `start` at cycle t:
  - `busy`=1 in cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - New `hi`/`lo` visible in cycle t+N+1, when `busy`=0.
  - `busy_or_start`=1 for cycles t … t+N: N+1 cycles total.
- Back-to-back: a new `start` is accepted in cycle t+N+1, the first cycle with `busy`=0.
- MTHI/MTLO: write visible in the cycle after issue.
- Operands are sampled only at the `start` edge. Changes to `rs_val`/`rt_val` during RUN have no effect.
- A `start` and an MT op cannot coincide, since there is one `md_op`.
- `start` is purely combinational from `md_op` and `busy`. No path from `rs_val`/`rt_val` to `start`/`busy`.

## Test plan
- **Reset then idle:** assert `reset` for 1 cycle, `md_op`=0 → `hi`=`lo`=0, `busy`=0, `busy_or_start`=0.
- **MULT:** `rs_val`=0xFFFFFFFE (−2), `rt_val`=3 →
  - `busy_or_start`=1 for 6 cycles, `busy`=1 for 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- **MULTU:** same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA after 5 busy cycles.
- **DIV/DIVU:**
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 busy cycles.
  - DIVU 7/0 → `hi`/`lo` unchanged, `busy` still 10 cycles.
- **Overlap and abort:**
  - MULT issued; in busy cycle 2, `md_op`=MTLO with `rs_val`=0x1234 → ignored; `lo` = product.
  - Separate run: `reset` during busy cycle 3 of DIV → `busy`=0, `hi`=`lo`=0, no later write.
- **MT and back-to-back:**
  - MTHI 0xDEADBEEF → `hi`=0xDEADBEEF next cycle, `busy`=0.
  - MULT 3×4 then MULTU held on `md_op` → second `start` in the cycle `busy` falls; `lo`=12 visible that cycle.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with HI/LO ownership.
// MULT/MULTU/DIV/DIVU run for a fixed number of busy cycles; the result is
// computed from operands latched at start and written on the final edge.
// MTHI/MTLO write directly while idle.
//
// Handshake: start is a combinational acceptance strobe. An MD-class op
// (1..4) on md_op is accepted on the edge where start=1, i.e. only while
// busy=0. There is no back-pressure signal other than busy_or_start. Any op
// 1..6 presented while busy=1 is dropped.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic        busy_or_start,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  md_op_e             r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_start;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_zero;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [31:0]        w_mag_a;
  logic [31:0]        w_mag_b;
  logic [31:0]        w_safe_b;
  logic [31:0]        w_q;
  logic [31:0]        w_r;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic               w_res_we;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;

  // start depends only on md_op and the registered state, never on operands.
  assign w_start       = (md_op >= 3'd1) && (md_op <= 3'd4) && (r_state == S_IDLE);
  assign start         = w_start;
  assign busy          = (r_state == S_RUN);
  assign busy_or_start = w_start | busy;
  assign hi            = r_hi;
  assign lo            = r_lo;

  // Products from latched operands; sign-extend to 64 bits for the signed form.
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Division on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no
  // overflow corner; a zero divisor is replaced by 1 to keep the datapath
  // defined, and the write is suppressed below.
  assign w_div_zero = (r_b == 32'd0);
  assign w_neg_a    = (r_op == OP_DIV) && r_a[31];
  assign w_neg_b    = (r_op == OP_DIV) && r_b[31];
  assign w_mag_a    = w_neg_a ? (32'd0 - r_a) : r_a;
  assign w_mag_b    = w_neg_b ? (32'd0 - r_b) : r_b;
  assign w_safe_b   = w_div_zero ? 32'd1 : w_mag_b;
  assign w_q        = w_mag_a / w_safe_b;
  assign w_r        = w_mag_a % w_safe_b;
  assign w_quo      = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q) : w_q;
  assign w_rem      = w_neg_a ? (32'd0 - w_r) : w_r;

  // Select the HI/LO result for the latched op.
  always_comb begin
    w_res_we = 1'b0;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT: begin
        w_res_we = 1'b1;
        {w_res_hi, w_res_lo} = w_prod_s;
      end
      OP_MULTU: begin
        w_res_we = 1'b1;
        {w_res_hi, w_res_lo} = w_prod_u;
      end
      OP_DIV, OP_DIVU: begin
        w_res_we = !w_div_zero;
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // Control FSM, countdown and HI/LO register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_NONE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_op    <= md_op_e'(md_op);
            r_a     <= rs_val;
            r_b     <= rt_val;
            r_cnt   <= (md_op <= 3'd2) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          end else if (md_op == OP_MTHI) begin
            r_hi <= rs_val;
          end else if (md_op == OP_MTLO) begin
            r_lo <= rs_val;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            if (w_res_we) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed sequence plus a few random ops, with a
// scoreboard of expected {hi,lo} popped whenever busy falls.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        start;
  logic        busy;
  logic        busy_or_start;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] hl_before = 64'd0;
  logic        prev_busy = 1'b0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .start(start), .busy(busy), .busy_or_start(busy_or_start), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {hi,lo} after op, given the prior {hi,lo}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    int     ia, ib;
    longint sa, sb;
    ia = a; ib = b; sa = ia; sb = ib;
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) return prev;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd4: begin
        if (b == 32'd0) return prev;
        return {a % b, a / b};
      end
      default: return prev;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present an MD op in an idle cycle, check acceptance, push result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    md_op = op; rs_val = a; rt_val = b;
    #1;
    chk("start", start, 1);
    chk("bos_at_start", busy_or_start, 1);
    chk("busy_at_start", busy, 0);
    hl_before = {m_hi, m_lo};
    e = model(op, a, b, {m_hi, m_lo});
    exp_q.push_back(e);
    {m_hi, m_lo} = e;
    step();
  endtask

  // Driver: walk the busy window, optionally intruding with MTLO or reset.
  task automatic wait_done(input logic [2:0] hold_op, input logic [31:0] ha, input logic [31:0] hb,
                           input int mtlo_at, input int abort_at, output int seen);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      k++;
      if (k == mtlo_at) begin
        md_op = 3'd6; rs_val = 32'h0000_1234;
      end else begin
        md_op = hold_op; rs_val = ha; rt_val = hb;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        void'(exp_q.pop_back());
        exp_q.push_back(64'd0);
        {m_hi, m_lo} = 64'd0;
      end
      #1;
      chk("start_while_busy", start, 0);
      chk("bos_while_busy", busy_or_start, 1);
      chk("hilo_held", {hi, lo}, hl_before);
      step();
      reset = 1'b0;
    end
    md_op = hold_op; rs_val = ha; rt_val = hb;
    seen = k;
  endtask

  // Scoreboard: each falling busy retires one expected {hi,lo}.
  always @(negedge clk) begin
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      chk("sb_has_entry", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sb_result", {hi, lo}, exp_q.pop_front());
    end
    prev_busy <= busy;
  end

  initial begin
    int          k;
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    step();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bos", busy_or_start, 0);
    chk("rst_start", start, 0);

    // MULT -2 * 3; operands scrambled during run must not matter
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done(3'd0, 32'h5555_AAAA, 32'h7, -1, -1, k);
    chk("mult_busy_cycles", k, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    #1;
    chk("mult_bos_after", busy_or_start, 0);
    step();

    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_done(3'd0, 32'd0, 32'd0, -1, -1, k);
    chk("multu_busy_cycles", k, 5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(3'd0, 32'd1, 32'd1, -1, -1, k);
    chk("div_busy_cycles", k, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd4, 32'd7, 32'd0);
    wait_done(3'd0, 32'd0, 32'd0, -1, -1, k);
    chk("divu0_busy_cycles", k, 10);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(3'd0, 32'd0, 32'd0, -1, -1, k);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);

    // MTLO during busy cycle 2 is dropped
    issue(3'd1, 32'h10, 32'h20);
    wait_done(3'd0, 32'd0, 32'd0, 2, -1, k);
    chk("ovl_busy_cycles", k, 5);
    chk("ovl_lo", lo, 32'h0000_0200);
    chk("ovl_hi", hi, 32'h0000_0000);

    md_op = 3'd5; rs_val = 32'hDEAD_BEEF;
    #1;
    chk("mthi_start", start, 0);
    chk("mthi_bos", busy_or_start, 0);
    step();
    md_op = 3'd0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_busy", busy, 0);
    m_hi = 32'hDEAD_BEEF;
    md_op = 3'd6; rs_val = 32'hCAFE_F00D;
    step();
    md_op = 3'd0;
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF);
    m_lo = 32'hCAFE_F00D;

    // reset during DIV busy cycle 3 aborts
    issue(3'd3, 32'd100, 32'd7);
    wait_done(3'd0, 32'd0, 32'd0, -1, 3, k);
    chk("abort_cycles", k, 3);
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (12) step();
    chk("abort_no_late_write", {hi, lo}, 64'd0);
    chk("abort_still_idle", busy, 0);

    // MULT 3x4 then MULTU held on md_op through the busy window
    issue(3'd1, 32'd3, 32'd4);
    wait_done(3'd2, 32'd5, 32'd6, -1, -1, k);
    chk("b2b_first_cycles", k, 5);
    #1;
    chk("b2b_lo_visible", lo, 32'd12);
    chk("b2b_start_on_fall", start, 1);
    issue(3'd2, 32'd5, 32'd6);
    wait_done(3'd0, 32'd0, 32'd0, -1, -1, k);
    chk("b2b_second_cycles", k, 5);
    chk("b2b_lo", lo, 32'd30);

    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 300));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
        default: b = $urandom;
      endcase
      issue(op, a, b);
      wait_done(3'd0, $urandom, $urandom, -1, -1, k);
      chk("rnd_cycles", k, (op <= 3'd2) ? 5 : 10);
      chk("rnd_hilo", {hi, lo}, {m_hi, m_lo});
    end

    repeat (2) step();
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
